// File: rtl/soc_system_clken_gen.sv
// rtl/soc_system_clken_gen.sv - PLL lock qualifier, staggered channel reset sequencer and programmable clock-enable dividers
// Defining CLKEN_LOSS_CNT_EN adds the saturating lock_loss_cnt output.
module soc_system_clken_gen #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 16,
   parameter int LOCK_CNT    = 1024,
   parameter int SYNC_STAGES = 2,
   parameter int RST_GAP     = 16
) (
   input  logic                    refclk,
   input  logic                    rst_n,
   input  logic                    pll_locked,
   input  logic [NUM_CH*DIV_W-1:0] div_cfg,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [NUM_CH-1:0]       ch_enable,
   output logic [NUM_CH-1:0]       clk_en,
   output logic [NUM_CH-1:0]       ch_rst_n,
`ifdef CLKEN_LOSS_CNT_EN
   output logic [7:0]              lock_loss_cnt,
`endif
   output logic                    locked
);
   localparam int LCW = $clog2(LOCK_CNT);
   localparam int GW  = $clog2(RST_GAP + 1);

   typedef enum logic [1:0] {IDLE, QUALIFY, RUN} state_t;
   state_t state, state_n;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lk_s;
   logic                   run_ok;
   logic [LCW-1:0]         lock_cnt, lock_cnt_n;
   logic [GW-1:0]          gap_cnt;
   logic [NUM_CH-1:0]      rst_q, pend, active, at_zero, reload;
   logic [DIV_W-1:0]       shadow  [NUM_CH];
   logic [DIV_W-1:0]       act_div [NUM_CH];
   logic [DIV_W-1:0]       cnt     [NUM_CH];

   assign lk_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lock_cnt <= '0;
      end else begin
         state    <= state_n;
         lock_cnt <= lock_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      lock_cnt_n = '0;
      case (state)
         IDLE: if (lk_s) state_n = QUALIFY;
         QUALIFY: begin
            if (!lk_s)                              state_n = IDLE;
            else if (lock_cnt == LCW'(LOCK_CNT - 1)) state_n = RUN;
            else                                    lock_cnt_n = lock_cnt + 1'b1;
         end
         RUN: if (!lk_s) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Gating with lk_s drops every output in the very cycle the lock loss is seen.
   assign run_ok   = (state == RUN) && lk_s;
   assign locked   = run_ok;
   assign ch_rst_n = rst_q & {NUM_CH{run_ok}};
   assign active   = ch_rst_n & ch_enable;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
         rst_q   <= '0;
      end else if (!run_ok) begin
         gap_cnt <= '0;
         rst_q   <= '0;
      end else if (gap_cnt == GW'(RST_GAP - 1)) begin
         gap_cnt <= '0;
         rst_q   <= (rst_q << 1) | NUM_CH'(1);
      end else begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end

   always_comb begin
      at_zero = '0;
      for (int i = 0; i < NUM_CH; i++) at_zero[i] = (cnt[i] == '0);
   end

   assign reload    = ~active | at_zero;
   assign clk_en    = active & at_zero;
   assign cfg_ready = ~|pend;

   // A new divisor is only taken at a reload point, so strobe spacing never mixes old and new values.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i]  <= '0;
            act_div[i] <= '0;
            cnt[i]     <= '0;
         end
         pend <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (reload[i]) begin
               if (pend[i]) begin
                  act_div[i] <= shadow[i];
                  cnt[i]     <= shadow[i];
               end else begin
                  cnt[i]     <= act_div[i];
               end
            end else begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
         if (cfg_valid && cfg_ready) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= div_cfg[i*DIV_W +: DIV_W];
            pend <= '1;
         end else begin
            pend <= pend & ~reload;
         end
      end
   end

`ifdef CLKEN_LOSS_CNT_EN
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n)
         lock_loss_cnt <= '0;
      else if (state == RUN && !lk_s && lock_loss_cnt != 8'hFF)
         lock_loss_cnt <= lock_loss_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_soc_system_clken_gen.sv
// tb/tb_soc_system_clken_gen.sv - self-checking bench for soc_system_clken_gen
module tb_soc_system_clken_gen;
   localparam int NUM_CH      = 4;
   localparam int DIV_W       = 16;
   localparam int LOCK_CNT    = 16;
   localparam int SYNC_STAGES = 2;
   localparam int RST_GAP     = 16;
   localparam int LOCK_LAT    = LOCK_CNT + SYNC_STAGES + 1;

   logic                    refclk = 1'b0;
   logic                    rst_n;
   logic                    pll_locked;
   logic [NUM_CH*DIV_W-1:0] div_cfg;
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [NUM_CH-1:0]       ch_enable;
   logic [NUM_CH-1:0]       clk_en;
   logic [NUM_CH-1:0]       ch_rst_n;
   logic                    locked;
`ifdef CLKEN_LOSS_CNT_EN
   logic [7:0]              lock_loss_cnt;
`endif

   always #5 refclk = ~refclk;

   soc_system_clken_gen #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CNT(LOCK_CNT),
      .SYNC_STAGES(SYNC_STAGES), .RST_GAP(RST_GAP)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
      .div_cfg(div_cfg), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .ch_enable(ch_enable), .clk_en(clk_en), .ch_rst_n(ch_rst_n),
`ifdef CLKEN_LOSS_CNT_EN
      .lock_loss_cnt(lock_loss_cnt),
`endif
      .locked(locked)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: lock = LOCK_CNT+1 consecutive synchronized-high samples,
   // resets by elapsed time since lock, dividers as count-up phase against D.
   bit              lk_hist[$];
   bit              m_run;
   int              m_hi, m_elapsed, m_loss;
   bit [NUM_CH-1:0] m_pend;
   int              m_div[NUM_CH], m_shadow[NUM_CH], m_since[NUM_CH];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_CH*DIV_W-1:0] pack(int d0, int d1, int d2, int d3);
      logic [NUM_CH*DIV_W-1:0] v;
      v = {DIV_W'(d3), DIV_W'(d2), DIV_W'(d1), DIV_W'(d0)};
      return v;
   endfunction

   function automatic bit m_rst(int i);
      return m_run && lk_hist[0] && (m_elapsed >= (i + 1) * RST_GAP);
   endfunction

   task automatic model_reset();
      lk_hist = {};
      for (int s = 0; s < SYNC_STAGES; s++) lk_hist.push_back(1'b0);
      m_run = 0; m_hi = 0; m_elapsed = 0; m_loss = 0; m_pend = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_div[i] = 0; m_shadow[i] = 0; m_since[i] = 0;
      end
   endtask

   task automatic model_edge();
      bit              lk = lk_hist[0];
      bit              ready_pre = (m_pend == '0);
      bit [NUM_CH-1:0] act;
      for (int i = 0; i < NUM_CH; i++) act[i] = m_rst(i) && ch_enable[i];
      for (int i = 0; i < NUM_CH; i++) begin
         if (act[i] && m_since[i] != m_div[i]) begin
            m_since[i]++;
         end else begin
            m_since[i] = 0;
            if (m_pend[i]) begin
               m_div[i]  = m_shadow[i];
               m_pend[i] = 1'b0;
            end
         end
      end
      if (cfg_valid && ready_pre) begin
         for (int i = 0; i < NUM_CH; i++) m_shadow[i] = int'(div_cfg[i*DIV_W +: DIV_W]);
         m_pend = '1;
      end
      if (m_run && lk) m_elapsed = (m_elapsed < 100000) ? m_elapsed + 1 : m_elapsed;
      else             m_elapsed = 0;
      if (m_run && !lk && m_loss < 255) m_loss++;
      if (m_run) begin
         m_run = lk;
      end else begin
         m_hi = lk ? m_hi + 1 : 0;
         if (m_hi == LOCK_CNT + 1) begin
            m_run = 1;
            m_hi  = 0;
         end
      end
      lk_hist.push_back(pll_locked);
      void'(lk_hist.pop_front());
   endtask

   task automatic check_outputs();
      bit [NUM_CH-1:0] e_rst, e_clk;
      for (int i = 0; i < NUM_CH; i++) begin
         e_rst[i] = m_rst(i);
         e_clk[i] = e_rst[i] && ch_enable[i] && (m_since[i] == m_div[i]);
      end
      chk("locked", locked, m_run && lk_hist[0]);
      chk("cfg_ready", cfg_ready, m_pend == '0);
      chk("ch_rst_n", ch_rst_n, e_rst);
      chk("clk_en", clk_en, e_clk);
`ifdef CLKEN_LOSS_CNT_EN
      chk("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
   endtask

   task automatic cyc();
      @(posedge refclk);
      if (rst_n) model_edge();
      @(negedge refclk);
      check_outputs();
   endtask

   task automatic wait_locked(output int n);
      n = 0;
      while (!locked && n < 200) begin
         cyc();
         n++;
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cfg_ready && n < 40) begin
         cyc();
         n++;
      end
      chk("cfg_ready_timeout", cfg_ready, 1);
   endtask

   initial begin
      int n;
      int rise[NUM_CH];
      int last[NUM_CH];
      int gap[NUM_CH];
      int st[$];

      rst_n = 0; pll_locked = 0; cfg_valid = 0; ch_enable = '0; div_cfg = '0;
      model_reset();
      repeat (3) @(negedge refclk);
      check_outputs();
      chk("reset_cfg_ready", cfg_ready, 1);

      // Divisors {0,1,4,65535}; channels idle, so they apply at once
      rst_n = 1; ch_enable = 4'b0111;
      div_cfg = pack(0, 1, 4, 65535); cfg_valid = 1;
      cyc();
      cfg_valid = 0;
      chk("cfg_ready_drop", cfg_ready, 0);
      cyc(); cyc();
      chk("cfg_ready_idle_apply", cfg_ready, 1);

      pll_locked = 1;
      wait_locked(n);
      chk("lock_latency", n, LOCK_LAT);

      for (int i = 0; i < NUM_CH; i++) rise[i] = -1;
      for (int k = 1; k <= 80; k++) begin
         cyc();
         for (int i = 0; i < NUM_CH; i++) if (rise[i] < 0 && ch_rst_n[i]) rise[i] = k;
      end
      for (int i = 0; i < NUM_CH; i++) chk($sformatf("rst_rise_%0d", i), rise[i], (i + 1) * RST_GAP);

      for (int i = 0; i < NUM_CH; i++) begin last[i] = -1; gap[i] = -1; end
      for (int k = 1; k <= 30; k++) begin
         cyc();
         for (int i = 0; i < 3; i++) if (clk_en[i]) begin
            if (last[i] >= 0) gap[i] = k - last[i];
            last[i] = k;
         end
      end
      chk("period_d0", gap[0], 1);
      chk("period_d1", gap[1], 2);
      chk("period_d4", gap[2], 5);

      // Live reconfig of ch0: 4 first, then 2 issued mid-count
      div_cfg = pack(4, 1, 4, 65535); cfg_valid = 1;
      cyc();
      cfg_valid = 0;
      wait_ready();
      n = 0;
      while (!clk_en[0] && n < 20) begin cyc(); n++; end
      chk("ch0_strobe_seen", clk_en[0], 1);
      cyc(); cyc();
      div_cfg = pack(2, 1, 4, 65535); cfg_valid = 1;
      cyc();
      chk("cfg_ready_busy", cfg_ready, 0);
      div_cfg = pack(7, 1, 4, 65535);
      cyc();
      cfg_valid = 0;
      st = {};
      for (int k = 5; k <= 14; k++) begin
         cyc();
         if (clk_en[0]) st.push_back(k);
      end
      while (st.size() < 3) st.push_back(-100);
      chk("reconfig_old_gap", st[0], 5);
      chk("reconfig_new_gap1", st[1] - st[0], 3);
      chk("reconfig_new_gap2", st[2] - st[1], 3);
      chk("cfg_ready_after_apply", cfg_ready, 1);

      // Random enables and reconfigs on ch1/ch2
      for (int k = 0; k < 300; k++) begin
         ch_enable[2:1] = 2'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            div_cfg   = pack(2, $urandom_range(0, 6), $urandom_range(0, 6), 65535);
            cfg_valid = 1;
         end else begin
            cfg_valid = 0;
         end
         cyc();
      end
      cfg_valid = 0; ch_enable = 4'b0111;
      wait_ready();

      // Maximum divisor: first strobe in the 65536th active cycle
      ch_enable = 4'b1111;
      n = 1;
      while (!clk_en[3] && n < 70000) begin cyc(); n++; end
      chk("d65535_first_strobe", n, 65536);

      // Lock loss while ch3 holds a pending divisor
      div_cfg = pack(2, 1, 4, 3); cfg_valid = 1;
      cyc();
      cfg_valid = 0;
      cyc();
      chk("cfg_pending_before_loss", cfg_ready, 0);
      pll_locked = 0;
      repeat (SYNC_STAGES + 1) cyc();
      chk("loss_locked", locked, 0);
      chk("loss_clk_en", clk_en, 0);
      chk("loss_ch_rst_n", ch_rst_n, 0);
      chk("loss_cfg_ready", cfg_ready, 1);
`ifdef CLKEN_LOSS_CNT_EN
      chk("loss_count", lock_loss_cnt, 1);
`endif

      pll_locked = 1;
      wait_locked(n);
      chk("relock_latency", n, LOCK_LAT);
      repeat (20) cyc();
      div_cfg = pack(9, 5, 6, 7); cfg_valid = 1;
      cyc();
      cfg_valid = 0;

      // Asynchronous reset between edges
      #2;
      rst_n = 0;
      model_reset();
      #1;
      check_outputs();
      chk("async_locked", locked, 0);
      chk("async_ch_rst_n", ch_rst_n, 0);
      chk("async_cfg_ready", cfg_ready, 1);
      cyc();
      rst_n = 1;
      wait_locked(n);
      chk("requalify_after_reset", n, LOCK_LAT);
      repeat (20) cyc();
      chk("div_zero_after_reset", clk_en[0], 1);

      // One-cycle glitch during qualification restarts the count
      pll_locked = 0;
      repeat (5) cyc();
      pll_locked = 1;
      repeat (13) cyc();
      chk("glitch_not_locked_yet", locked, 0);
      pll_locked = 0;
      cyc();
      pll_locked = 1;
      wait_locked(n);
      chk("glitch_relock", n, LOCK_LAT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/soc_system_clken_gen.md
Name: soc_system_clken_gen

Overview:
- N-channel clock-enable generator and reset sequencer, running in a single PLL output domain.
- Qualifies the raw PLL lock indication and produces a stable `locked`.
- Releases per-channel resets in a staggered order.
- Generates divided single-cycle clock-enable strobes from runtime-programmable divisors, so multiple slow subsystem rates are derived without extra PLL outputs.

Parameters:
- NUM_CH, 4, number of clock-enable channels (1..16)
- DIV_W, 16, width of each channel divisor
- LOCK_CNT, 1024, consecutive synchronized-lock-high cycles required before `locked` asserts (>=2)
- SYNC_STAGES, 2, lock synchronizer depth (>=2)
- RST_GAP, 16, cycles between successive channel reset releases (>=1)

Ports:
- refclk, in, 1, sole clock
- rst_n, in, 1, asynchronous active-low reset
- pll_locked, in, 1, raw asynchronous PLL lock indication
- div_cfg, in, NUM_CH*DIV_W, channel i divisor-minus-one at [i*DIV_W +: DIV_W]
- cfg_valid, in, 1, new div_cfg offered
- cfg_ready, out, 1, shadow register free to accept div_cfg
- ch_enable, in, NUM_CH, per-channel run enable
- clk_en, out, NUM_CH, per-channel one-cycle enable strobe
- ch_rst_n, out, NUM_CH, per-channel active-low reset, sequenced
- locked, out, 1, qualified lock

Behaviour:
- Reset (rst_n=0, async):
  - clk_en=0, ch_rst_n=0, locked=0, cfg_ready=1.
  - FSM=IDLE.
  - Active divisors and shadow divisors = 0; all counters = 0.
- Synchronizer: pll_locked passes through SYNC_STAGES flops to produce lk_s; all logic uses lk_s only.
- FSM states:
  - IDLE: lock counter cleared. lk_s=1 -> QUALIFY.
  - QUALIFY: counts lk_s-high cycles. Any lk_s=0 -> IDLE with counter cleared. Count reaching LOCK_CNT-1 -> RUN; locked=1 registered on entry.
  - RUN: lk_s=0 -> IDLE next cycle; locked, all ch_rst_n and all clk_en drop to 0 in that same cycle; channel counters reload.
- Reset sequencing, in RUN only:
  - Gap counter starts at RUN entry.
  - ch_rst_n[i] rises (i+1)*RST_GAP cycles after locked rises, lowest index first.
  - Once high, it stays high until RUN is exited.
- Channel activity: channel i is active when RUN & ch_rst_n[i] & ch_enable[i]. An inactive channel holds its counter at its active divisor and drives clk_en[i]=0.
- Division, active channel with divisor D:
  - Counter starts at D and decrements each active cycle.
  - When the counter is 0, clk_en[i]=1 for that cycle and the counter reloads D.
  - First strobe is in the (D+1)th active cycle; period is D+1 cycles.
  - D=0 -> clk_en[i]=1 every active cycle.
  - Width is exactly DIV_W bits; no overflow is possible.
- Config handshake:
  - A transfer occurs when cfg_valid & cfg_ready. div_cfg is latched into the shadow and cfg_ready goes 0 the next cycle.
  - Each channel copies its shadow into its active divisor at its next reload point (counter==0 while active). An inactive channel copies immediately.
  - Updates are glitch-free: no strobe spacing other than old D+1 or new D+1 is ever produced.
  - cfg_ready returns to 1 the cycle after every channel has applied its shadow.
  - cfg_valid while cfg_ready=0 is ignored.
- Simultaneous events:
  - Lock loss with a pending config: the pending shadow is applied to all channels immediately; cfg_ready=1 next cycle.
  - ch_enable falling mid-count: counter reloads; no partial strobe.
- Reset mid-operation: rst_n=0 asynchronously forces all reset values; divisors return to 0.

Optional Feature:
- Macro CLKEN_LOSS_CNT_EN.
- When defined:
  - Adds output lock_loss_cnt [7:0].
  - It increments on each RUN->IDLE transition caused by lk_s=0, saturating at 255.
  - Cleared only by rst_n.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Lock qualification:
  - Stimulus: LOCK_CNT=16; pll_locked rises and stays high.
  - Required: locked=1 at 16+SYNC_STAGES+1 cycles (±1 for FSM entry).
  - Stimulus: a 1-cycle low glitch at count 10.
  - Required: counter restarts; locked is delayed accordingly.
- Reset stagger:
  - Stimulus: NUM_CH=4, RST_GAP=16.
  - Required: ch_rst_n[0..3] rise at 16, 32, 48 and 64 cycles after locked, in that order.
- Division:
  - Stimulus: divisors {0,1,4,65535} with all channels enabled.
  - Required: strobe periods 1, 2, 5 and 65536; first strobe in the D+1th active cycle.
- Live reconfig:
  - Stimulus: ch0 D=4 -> 2, issued mid-count.
  - Required: gaps ...5,5,3,3...; cfg_ready low until applied; a second cfg_valid while busy is ignored.
- Lock loss in RUN:
  - Stimulus: pll_locked drops while a config is pending.
  - Required: within SYNC_STAGES+1 cycles, locked=0, clk_en=0, ch_rst_n=0; cfg_ready=1; lock_loss_cnt increments (if CLKEN_LOSS_CNT_EN).
- Async reset:
  - Stimulus: rst_n asserted mid-RUN between clock edges.
  - Required: all outputs at reset values immediately; recovery requires full requalification.
